// File: rtl/order_sequencer_if.sv
// order_sequencer_if: handshake bundle between the order cache/compute engine side (master) and order_sequencer (slave)
// master drives task_start, abort, calculate_start, order, id, exec_done; slave drives the rest.
interface order_sequencer_if;
  logic       task_start;
  logic       abort;
  logic       pop_order_en;
  logic       calculate_start;
  logic [2:0] order;
  logic [7:0] id;
  logic       exec_start;
  logic [2:0] exec_order;
  logic [7:0] exec_id;
  logic       exec_done;
  logic       busy;
  logic       task_done;
  logic       task_error;
  logic [1:0] err_code;
  logic [9:0] orders_done;
  modport master (
    output task_start, abort, calculate_start, order, id, exec_done,
    input  pop_order_en, exec_start, exec_order, exec_id, busy, task_done, task_error, err_code, orders_done
  );
  modport slave (
    input  task_start, abort, calculate_start, order, id, exec_done,
    output pop_order_en, exec_start, exec_order, exec_id, busy, task_done, task_error, err_code, orders_done
  );
endinterface

// File: rtl/order_sequencer.sv
// order_sequencer: pops cached orders one by one, dispatches executable ones to the compute engine, reports task status
// Ports: system_clk (rising edge), rst_n (async active-low), bus (order_sequencer_if.slave):
//   task control  task_start, abort -> busy, task_done, task_error, err_code, orders_done
//   order cache   pop_order_en -> calculate_start, order, id
//   engine        exec_start, exec_order, exec_id -> exec_done
module order_sequencer #(
  parameter logic [31:0] WDOG_LIMIT = 32'd100_000_000,
  parameter int unsigned MAX_ORDERS = 512
) (
  input logic              system_clk,
  input logic              rst_n,
  order_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, POP, LOAD, DISPATCH, RUN, FINISH} state_t;
  state_t      st, nxt;
  logic [9:0]  pop_count;
  logic [1:0]  load_cnt;
  logic [31:0] wdog;
  logic        accept, full, legal, wdog_exp, err_set;
  logic [1:0]  err_val;
  assign accept   = st == IDLE && bus.task_start;
  assign full     = pop_count >= 10'(MAX_ORDERS);
  assign legal    = bus.order != 3'd0 && bus.order < 3'd5;
  // expiry is flagged one count early so FINISH lands exactly WDOG_LIMIT cycles after exec_start
  assign wdog_exp = wdog >= WDOG_LIMIT - 32'd1;
  always_ff @(posedge system_clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    err_set = 1'b0;
    err_val = 2'd0;
    if (bus.abort && st != IDLE && st != FINISH) begin
      nxt = FINISH;
      err_set = 1'b1;
      err_val = 2'd3;
    end else
      case (st)
        IDLE: nxt = bus.task_start ? POP : IDLE;
        POP: begin
          nxt = full ? FINISH : LOAD;
          err_set = full;
          err_val = 2'd3;
        end
        LOAD:
          if (bus.calculate_start) begin
            nxt = bus.order == 3'd0 ? POP : legal ? DISPATCH : FINISH;
            err_set = bus.order > 3'd5;
            err_val = 2'd1;
          end else if (load_cnt == 2'd3) begin
            nxt = FINISH;
            err_set = 1'b1;
            err_val = 2'd2;
          end
        DISPATCH: nxt = RUN;
        RUN:
          if (bus.exec_done) nxt = POP;
          else if (wdog_exp) begin
            nxt = FINISH;
            err_set = 1'b1;
            err_val = 2'd2;
          end
        FINISH: nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    bus.busy = st != IDLE;
    bus.pop_order_en = st == POP && !full;
    bus.task_done = st == FINISH;
  end
  // exec_start is registered off DISPATCH, giving the two-cycle calculate_start -> exec_start latency
  always_ff @(posedge system_clk or negedge rst_n)
    if (!rst_n) begin
      pop_count <= '0;
      load_cnt <= '0;
      wdog <= '0;
      bus.exec_start <= 1'b0;
      bus.exec_order <= '0;
      bus.exec_id <= '0;
      bus.orders_done <= '0;
      bus.err_code <= '0;
      bus.task_error <= 1'b0;
    end else begin
      pop_count <= accept ? '0 : bus.pop_order_en && pop_count != '1 ? pop_count + 10'd1 : pop_count;
      load_cnt <= st == LOAD ? load_cnt + 2'd1 : 2'd0;
      wdog <= st == DISPATCH ? '0 : st == RUN && wdog != '1 ? wdog + 32'd1 : wdog;
      bus.exec_start <= st == DISPATCH && nxt == RUN;
      if (st == LOAD && bus.calculate_start && legal) begin
        bus.exec_order <= bus.order;
        bus.exec_id <= bus.id;
      end
      bus.orders_done <= accept ? '0 : st == RUN && nxt == POP && bus.orders_done != '1 ? bus.orders_done + 10'd1 : bus.orders_done;
      bus.err_code <= accept ? 2'd0 : err_set ? err_val : bus.err_code;
      bus.task_error <= accept ? 1'b0 : st == FINISH ? bus.err_code != 2'd0 : bus.task_error;
    end
endmodule

// File: doc/order_sequencer.md
ORDER_SEQUENCER -- requirements
Module: order_sequencer

Interface
REQ-001 SHALL have parameter WDOG_LIMIT, default 32'd100_000_000, max cycles allowed between exec_start and exec_done.
REQ-002 SHALL have parameter MAX_ORDERS, default 512, max orders popped per task (order RAM depth).
REQ-003 SHALL have port system_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port task_start  input  1  one-cycle pulse requesting execution of the cached order list.
REQ-006 SHALL have port abort  input  1  level; forces return to IDLE with error.
REQ-007 SHALL have port pop_order_en  output  1  one-cycle pulse popping the next cached order.
REQ-008 SHALL have port calculate_start  input  1  pulse one cycle after pop_order_en; order fields valid while high.
REQ-009 SHALL have port order  input  3  opcode of the popped order.
REQ-010 SHALL have port id  input  8  tag of the popped order.
REQ-011 SHALL have port exec_start  output  1  one-cycle pulse launching the compute engine.
REQ-012 SHALL have port exec_order  output  3  registered opcode, stable from exec_start until exec_done.
REQ-013 SHALL have port exec_id  output  8  registered tag, same stability as exec_order.
REQ-014 SHALL have port exec_done  input  1  one-cycle pulse from the engine ending the current order.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port task_done  output  1  one-cycle pulse at task end (normal or error).
REQ-017 SHALL have port task_error  output  1  sticky error flag, cleared on the next accepted task_start.
REQ-018 SHALL have port err_code  output  2  0 none, 1 illegal opcode, 2 watchdog, 3 order overflow or abort.
REQ-019 SHALL have port orders_done  output  10  count of orders completed via exec_done in the current task.

Function
REQ-020 SHALL implement states IDLE, POP, LOAD, DISPATCH, RUN, FINISH.
REQ-021 IDLE: task_start=1 -> POP, clear orders_done, pop_count, task_error and err_code; task_start outside IDLE is ignored.
REQ-022 POP: assert pop_order_en for exactly one cycle, increment the 10-bit pop_count, go to LOAD.
REQ-023 LOAD: wait for calculate_start; on it, decode order: 5 -> FINISH with no error; 0 -> NOP, back to POP; 1-4 -> latch exec_order/exec_id, go to DISPATCH; 6-7 -> FINISH with err_code=1.
REQ-024 LOAD without calculate_start within 4 cycles -> FINISH with err_code=2.
REQ-025 DISPATCH: assert exec_start for one cycle, clear the 32-bit watchdog counter, go to RUN.
REQ-026 RUN: increment the watchdog each cycle; on exec_done, increment orders_done and go to POP; if the watchdog reaches WDOG_LIMIT first -> FINISH with err_code=2.
REQ-027 exec_done and watchdog expiry in the same cycle -> exec_done wins.
REQ-028 POP entered with pop_count == MAX_ORDERS -> FINISH with err_code=3 and no pop issued.
REQ-029 exec_done outside RUN SHALL be ignored; calculate_start outside LOAD SHALL be ignored.
REQ-030 abort=1 in any non-IDLE state -> FINISH next cycle with err_code=3; abort in IDLE has no effect.
REQ-031 FINISH: assert task_done for one cycle, set task_error = (err_code != 0), go to IDLE.
REQ-032 Latency: task_start -> pop_order_en 1 cycle; calculate_start -> exec_start 2 cycles; exec_done -> next pop_order_en 1 cycle.
REQ-033 Counters SHALL saturate rather than wrap; orders_done max 1023.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE and all outputs, counters and err_code to 0.
REQ-035 Reset asserted mid-task SHALL drop exec_start/pop_order_en immediately; no task_done is issued.

Verification
REQ-036 List {1,id=3},{2,id=7},{5}: task_start -> 3 pops, exec_start with (1,3) then (2,7), task_done, orders_done=2, task_error=0.
REQ-037 List {0},{0},{5}: 3 pops, no exec_start, task_done, orders_done=0.
REQ-038 List {6}: 1 pop, task_done, task_error=1, err_code=1.
REQ-039 WDOG_LIMIT=16, exec_done withheld: task_done 16 cycles after exec_start, err_code=2; a late exec_done is ignored.
REQ-040 MAX_ORDERS=4, list without end opcode: exactly 4 pops, then task_done with err_code=3.
REQ-041 abort during RUN, then rst_n pulse mid-second task: err_code=3 after abort; immediate IDLE and all-zero outputs on reset.
